// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-processing sequencer:
// FSM state encoding, ARM condition codes, DP opcodes and shifter encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'ha;
  localparam logic [3:0] CondLt = 4'hb;
  localparam logic [3:0] CondGt = 4'hc;
  localparam logic [3:0] CondLe = 4'hd;
  localparam logic [3:0] CondAl = 4'he;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpRsb = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpRsc = 4'b0111;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpTeq = 4'b1001;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpCmn = 4'b1011;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpBic = 4'b1110;
  localparam logic [3:0] OpMvn = 4'b1111;

  localparam logic [2:0] ShLsl = 3'b000;
  localparam logic [2:0] ShLsr = 3'b010;
  localparam logic [2:0] ShAsr = 3'b100;
  localparam logic [2:0] ShRor = 3'b110;
  localparam logic [2:0] ShRrx = 3'b111;

  // Compare-class ops update flags only and never write a register.
  function automatic logic is_compare(logic [3:0] op);
    return op inside {OpTst, OpTeq, OpCmp, OpCmn};
  endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/board (slave).
interface dp_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        ir_valid;
  logic [3:0]  nzcv;
  logic        write_ir;
  logic        write_pc;
  logic [3:0]  r_addr_a;
  logic [3:0]  r_addr_b;
  logic [3:0]  r_addr_c;
  logic [3:0]  w_addr;
  logic        write_reg;
  logic        write_nzcv;
  logic [3:0]  alu_op;
  logic [2:0]  shift_op;
  logic [7:0]  shift_num;
  logic        shift_num_sel;
  logic        b_imm;
  logic [31:0] imm;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  run, ir, ir_valid, nzcv,
    output write_ir, write_pc, r_addr_a, r_addr_b, r_addr_c, w_addr, write_reg, write_nzcv,
           alu_op, shift_op, shift_num, shift_num_sel, b_imm, imm, illegal, state
  );

  modport slave (
    output run, ir, ir_valid, nzcv,
    input  write_ir, write_pc, r_addr_a, r_addr_b, r_addr_c, w_addr, write_reg, write_nzcv,
           alu_op, shift_op, shift_num, shift_num_sel, b_imm, imm, illegal, state
  );
endinterface

// File: rtl/cond_check.sv
// ARM condition evaluator: cond field against {N,Z,C,V}; 1111 never passes.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  // Full condition table.
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CondEq:  pass_o = z;
      CondNe:  pass_o = ~z;
      CondCs:  pass_o = c;
      CondCc:  pass_o = ~c;
      CondMi:  pass_o = n;
      CondPl:  pass_o = ~n;
      CondVs:  pass_o = v;
      CondVc:  pass_o = ~v;
      CondHi:  pass_o = c & ~z;
      CondLs:  pass_o = ~c | z;
      CondGe:  pass_o = (n == v);
      CondLt:  pass_o = (n != v);
      CondGt:  pass_o = ~z & (n == v);
      CondLe:  pass_o = z | (n != v);
      CondAl:  pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control FSM for the data-processing datapath.
// Optional feature: define CTRL_SINGLE_STEP_EN to launch exactly one instruction per
// rising edge of run; otherwise run is level-sensitive and instructions run back-to-back.
module dp_sequencer
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dp_sequencer_if.master bus_io
);
  state_e      state_q, state_d;
  logic        fetch_q, fetch_d;
  logic        write_reg_q, write_reg_d;
  logic        write_nzcv_q, write_nzcv_d;
  logic        illegal_q, illegal_d;
  logic        cond_pass, go, again, writes_rd, rd_is_pc;
  logic [31:0] ir;

  assign ir        = bus_io.ir;
  assign writes_rd = ~is_compare(ir[24:21]);
  assign rd_is_pc  = (ir[15:12] == 4'hf);

  cond_check u_cond_check (
    .cond_i (ir[31:28]),
    .nzcv_i (bus_io.nzcv),
    .pass_o (cond_pass)
  );

`ifdef CTRL_SINGLE_STEP_EN
  logic run_q;
  // Edge detect so a held run launches only one instruction.
  always_ff @(posedge clk) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= bus_io.run;
  end
  assign go    = bus_io.run & ~run_q;
  assign again = 1'b0;
`else
  assign go    = bus_io.run;
  assign again = bus_io.run;
`endif

  // Next state plus the strobes for the state being entered.
  always_comb begin
    state_d      = state_q;
    write_reg_d  = 1'b0;
    write_nzcv_d = 1'b0;
    illegal_d    = illegal_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        if (bus_io.ir_valid) begin
          if (!cond_pass) begin
            state_d = again ? StFetch : StIdle;
          end else if (ir[27:26] != 2'b00) begin
            illegal_d = 1'b1;
            state_d   = again ? StFetch : StIdle;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        state_d      = StWb;
        write_reg_d  = writes_rd & ~rd_is_pc;
        write_nzcv_d = ~writes_rd | ir[20];
        if (writes_rd && rd_is_pc) illegal_d = 1'b1;
      end
      StWb:    state_d = again ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
    fetch_d = (state_d == StFetch);
  end

  // State and registered strobes; reset wins in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      fetch_q      <= 1'b0;
      write_reg_q  <= 1'b0;
      write_nzcv_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= fetch_d;
      write_reg_q  <= write_reg_d;
      write_nzcv_q <= write_nzcv_d;
      illegal_q    <= illegal_d;
    end
  end

  // Field decode, driven only from DECODE through WB.
  always_comb begin
    bus_io.r_addr_a      = 4'h0;
    bus_io.r_addr_b      = 4'h0;
    bus_io.r_addr_c      = 4'h0;
    bus_io.w_addr        = 4'h0;
    bus_io.alu_op        = 4'h0;
    bus_io.shift_op      = ShLsl;
    bus_io.shift_num     = 8'h00;
    bus_io.shift_num_sel = 1'b0;
    bus_io.b_imm         = 1'b0;
    bus_io.imm           = 32'h0;
    if (state_q inside {StDecode, StExec, StWb}) begin
      bus_io.r_addr_a = ir[19:16];
      bus_io.r_addr_b = ir[3:0];
      bus_io.r_addr_c = ir[11:8];
      bus_io.w_addr   = ir[15:12];
      bus_io.alu_op   = ir[24:21];
      if (ir[25]) begin
        bus_io.b_imm     = 1'b1;
        bus_io.imm       = {24'h0, ir[7:0]};
        bus_io.shift_op  = ShRor;
        bus_io.shift_num = {3'b000, ir[11:8], 1'b0};
      end else begin
        unique case (ir[6:5])
          2'b00:   bus_io.shift_op = ShLsl;
          2'b01:   bus_io.shift_op = ShLsr;
          2'b10:   bus_io.shift_op = ShAsr;
          default: bus_io.shift_op = ShRor;
        endcase
        if (ir[4]) begin
          bus_io.shift_num_sel = 1'b1;
        end else begin
          bus_io.shift_num = {3'b000, ir[11:7]};
          // ROR by zero encodes rotate-right-extended.
          if (ir[6:5] == 2'b11 && ir[11:7] == 5'd0) bus_io.shift_op = ShRrx;
        end
      end
    end
  end

  assign bus_io.write_ir   = fetch_q;
  assign bus_io.write_pc   = fetch_q;
  assign bus_io.write_reg  = write_reg_q;
  assign bus_io.write_nzcv = write_nzcv_q;
  assign bus_io.illegal    = illegal_q;
  assign bus_io.state      = state_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: per-cycle expected traces go into a scoreboard queue when an
// instruction is launched and are popped and compared every falling edge.
module tb_dp_sequencer;
  logic clk = 1'b0;
  logic rst;

  dp_sequencer_if bus ();

  dp_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       wir;
    logic       wreg;
    logic       wnz;
    logic       ill;
    logic [3:0] wa;
    logic [3:0] op;
  } exp_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [3:0]  f;
    logic [3:0]  a, b, c, op;
    logic [2:0]  sop;
    logic [7:0]  snum;
    logic        sel, bimm;
    logic [31:0] imm;
    logic        wreg, wnz;
  } op_t;

  exp_t  sb[$];
  exp_t  pend[$];
  exp_t  e_mon;
  int    n_total = 0;
  int    n_bad = 0;
  logic  exp_ill = 1'b0;
  string tag = "init";
  op_t   ops[10];

  localparam logic [31:0] IrAdd = 32'hE0812003;
  localparam logic [31:0] IrCmp = 32'hE3510010;
  localparam logic [31:0] IrLdr = 32'hE5912000;
  localparam logic [31:0] IrPc  = 32'hE081F003;

  function automatic logic [72:0] all_outs();
    return {bus.write_ir, bus.write_pc, bus.r_addr_a, bus.r_addr_b, bus.r_addr_c, bus.w_addr,
            bus.write_reg, bus.write_nzcv, bus.alu_op, bus.shift_op, bus.shift_num,
            bus.shift_num_sel, bus.b_imm, bus.imm, bus.illegal, bus.state};
  endfunction

  // Scoreboard checker: one expected entry per falling edge while entries are queued.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      n_total++;
      if ({bus.state, bus.write_ir, bus.write_pc, bus.write_reg, bus.write_nzcv, bus.illegal,
           bus.w_addr, bus.alu_op} !==
          {e_mon.st, e_mon.wir, e_mon.wir, e_mon.wreg, e_mon.wnz, e_mon.ill, e_mon.wa,
           e_mon.op}) begin
        n_bad++;
        $display("FAIL %s cycle: got st=%0d wir=%b wpc=%b wreg=%b wnz=%b ill=%b wa=%h op=%h, want st=%0d wir=%b wpc=%b wreg=%b wnz=%b ill=%b wa=%h op=%h",
                 tag, bus.state, bus.write_ir, bus.write_pc, bus.write_reg, bus.write_nzcv,
                 bus.illegal, bus.w_addr, bus.alu_op, e_mon.st, e_mon.wir, e_mon.wir,
                 e_mon.wreg, e_mon.wnz, e_mon.ill, e_mon.wa, e_mon.op);
      end
    end
  end

  task automatic expect_cyc(input logic [2:0] st, input logic wir, input logic wreg,
                            input logic wnz, input logic [31:0] i);
    exp_t e;
    logic act;
    act    = (st >= 3'd2) && (st <= 3'd4);
    e.st   = st;
    e.wir  = wir;
    e.wreg = wreg;
    e.wnz  = wnz;
    e.ill  = exp_ill;
    e.wa   = act ? i[15:12] : 4'h0;
    e.op   = act ? i[24:21] : 4'h0;
    pend.push_back(e);
  endtask

  // IDLE, FETCH, DECODE, EXEC, WB, IDLE for an instruction that executes.
  task automatic push_exec(input logic [31:0] i, input logic wreg, input logic wnz);
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, i);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, i);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, i);
    expect_cyc(3'd3, 1'b0, 1'b0, 1'b0, i);
    expect_cyc(3'd4, 1'b0, wreg, wnz, i);
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, i);
  endtask

  // Launch from IDLE; returns just after the IDLE->FETCH edge.
  task automatic start(input logic [31:0] i, input logic [3:0] f, input logic valid,
                       input logic keep_run);
    @(posedge clk);
    #1;
    bus.run      = 1'b1;
    bus.ir       = i;
    bus.nzcv     = f;
    bus.ir_valid = valid;
    while (pend.size() > 0) sb.push_back(pend.pop_front());
    @(posedge clk);
    #1;
    if (!keep_run) bus.run = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() > 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    n_total++;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL %s timeout: %0d entries pending, want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    tag          = "reset";
    rst          = 1'b0;
    bus.run      = 1'b0;
    bus.ir       = 32'h0;
    bus.ir_valid = 1'b0;
    bus.nzcv     = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus.state !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    n_total++;
    if (bus.illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_illegal: got %b want 0", bus.illegal);
    end
    n_total++;
    if (all_outs() !== 73'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_operands();
    for (int k = 0; k < 10; k++) begin
      tag = $sformatf("operand%0d", k);
      push_exec(ops[k].ir, ops[k].wreg, ops[k].wnz);
      start(ops[k].ir, ops[k].f, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      n_total++;
      if ({bus.r_addr_a, bus.r_addr_b, bus.r_addr_c, bus.alu_op, bus.shift_op, bus.shift_num,
           bus.shift_num_sel, bus.b_imm, bus.imm} !==
          {ops[k].a, ops[k].b, ops[k].c, ops[k].op, ops[k].sop, ops[k].snum, ops[k].sel,
           ops[k].bimm, ops[k].imm}) begin
        n_bad++;
        $display("FAIL %s decode: got a=%h b=%h c=%h op=%h sop=%b snum=%0d sel=%b bimm=%b imm=%h, want a=%h b=%h c=%h op=%h sop=%b snum=%0d sel=%b bimm=%b imm=%h",
                 tag, bus.r_addr_a, bus.r_addr_b, bus.r_addr_c, bus.alu_op, bus.shift_op,
                 bus.shift_num, bus.shift_num_sel, bus.b_imm, bus.imm, ops[k].a, ops[k].b,
                 ops[k].c, ops[k].op, ops[k].sop, ops[k].snum, ops[k].sel, ops[k].bimm,
                 ops[k].imm);
      end
      drain();
    end
  endtask

  task automatic test_cond_fail();
    logic [31:0] irs[7];
    logic [3:0]  fl[7];
    irs = '{32'h03A00005, 32'hF0812003, 32'hC0812003, 32'h80812003, 32'h60812003,
            32'hA0812003, 32'h10812003};
    fl  = '{4'b0000, 4'b1111, 4'b0100, 4'b0110, 4'b0000, 4'b1000, 4'b0100};
    for (int k = 0; k < 7; k++) begin
      tag = $sformatf("condfail%0d", k);
      expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, irs[k]);
      expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, irs[k]);
      expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, irs[k]);
      expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, irs[k]);
      start(irs[k], fl[k], 1'b1, 1'b0);
      drain();
    end
  endtask

  task automatic test_stall();
    tag = "stall";
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrAdd);
    repeat (4) expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd3, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd4, 1'b0, 1'b1, 1'b0, IrAdd);
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrAdd);
    start(IrAdd, 4'h0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.ir_valid = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    tag = "back_to_back";
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd3, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd4, 1'b0, 1'b1, 1'b0, IrAdd);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrCmp);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrCmp);
    expect_cyc(3'd3, 1'b0, 1'b0, 1'b0, IrCmp);
    expect_cyc(3'd4, 1'b0, 1'b0, 1'b1, IrCmp);
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrCmp);
    start(IrAdd, 4'h0, 1'b1, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.ir  = IrCmp;
    bus.run = 1'b0;
    drain();
  endtask

  task automatic test_illegal();
    tag = "illegal";
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrLdr);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrLdr);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrLdr);
    exp_ill = 1'b1;
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrLdr);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrLdr);
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrLdr);
    start(IrLdr, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    drain();
    tag = "illegal_sticky";
    push_exec(IrAdd, 1'b1, 1'b0);
    start(IrAdd, 4'h0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    tag = "reset_mid";
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrAdd);
    expect_cyc(3'd3, 1'b0, 1'b0, 1'b0, IrAdd);
    start(IrAdd, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (all_outs() !== 73'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", all_outs());
    end
    exp_ill = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain();
  endtask

  task automatic test_rd_pc();
    tag = "rd_pc";
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrPc);
    expect_cyc(3'd1, 1'b1, 1'b0, 1'b0, IrPc);
    expect_cyc(3'd2, 1'b0, 1'b0, 1'b0, IrPc);
    expect_cyc(3'd3, 1'b0, 1'b0, 1'b0, IrPc);
    exp_ill = 1'b1;
    expect_cyc(3'd4, 1'b0, 1'b0, 1'b0, IrPc);
    expect_cyc(3'd0, 1'b0, 1'b0, 1'b0, IrPc);
    start(IrPc, 4'h0, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    ops[0] = '{32'hE0812003, 4'h0, 4'd1, 4'd3, 4'd0, 4'b0100, 3'b000, 8'd0, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0};
    ops[1] = '{32'h03A00005, 4'b0100, 4'd0, 4'd5, 4'd0, 4'b1101, 3'b110, 8'd0, 1'b0, 1'b1,
               32'h5, 1'b1, 1'b0};
    ops[2] = '{32'hE3510010, 4'h0, 4'd1, 4'd0, 4'd0, 4'b1010, 3'b110, 8'd0, 1'b0, 1'b1,
               32'h10, 1'b0, 1'b1};
    ops[3] = '{32'hE1A00060, 4'h0, 4'd0, 4'd0, 4'd0, 4'b1101, 3'b111, 8'd0, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0};
    ops[4] = '{32'hE0912313, 4'h0, 4'd1, 4'd3, 4'd3, 4'b0100, 3'b000, 8'd0, 1'b1, 1'b0,
               32'h0, 1'b1, 1'b1};
    ops[5] = '{32'hE0812143, 4'h0, 4'd1, 4'd3, 4'd1, 4'b0100, 3'b100, 8'd2, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0};
    ops[6] = '{32'hE3A004FF, 4'h0, 4'd0, 4'hF, 4'd4, 4'b1101, 3'b110, 8'd8, 1'b0, 1'b1,
               32'hFF, 1'b1, 1'b0};
    ops[7] = '{32'hE1A00160, 4'h0, 4'd0, 4'd0, 4'd1, 4'b1101, 3'b110, 8'd2, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0};
    ops[8] = '{32'hE1000002, 4'h0, 4'd0, 4'd2, 4'd0, 4'b1000, 3'b000, 8'd0, 1'b0, 1'b0,
               32'h0, 1'b0, 1'b1};
    ops[9] = '{32'hB0812003, 4'b1000, 4'd1, 4'd3, 4'd0, 4'b0100, 3'b000, 8'd0, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0};

    test_reset();
    test_operands();
    test_cond_fail();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_rd_pc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Multi-cycle control unit for the data-processing datapath: the fetch unit, register file, barrel shifter, ALU and NZCV register. It decodes the instruction held in IR and evaluates its condition field against NZCV. It then drives the per-phase strobes and select fields for the other blocks: IR/PC write, register addresses, shifter/ALU controls, register write-back and flag update. It sits between the board top-level and the datapath, replacing manual switch-driven control.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- run  in  1  enable; sequencing proceeds while high (see Configuration).
- ir  in  32  current instruction from the fetch unit.
- ir_valid  in  1  fetch unit reports IR holds a fetched instruction.
- nzcv  in  4  current flags {N,Z,C,V}.
- write_ir, write_pc  out  1 each  fetch strobes.
- r_addr_a, r_addr_b, r_addr_c  out  4 each  Rn, Rm, Rs read addresses.
- w_addr  out  4  Rd write address.
- write_reg  out  1  register write-back strobe.
- write_nzcv  out  1  flag update strobe.
- alu_op  out  4  ARM opcode IR[24:21].
- shift_op  out  3  shifter operation.
- shift_num  out  8  immediate shift amount.
- shift_num_sel  out  1  1 = shift amount from Rs (r_data_c[7:0]).
- b_imm  out  1  1 = shifter data is imm.
- imm  out  32  zero-extended IR[7:0].
- illegal  out  1  sticky non-DP / Rd=15 fault.
- state  out  3  FSM state, for LEDs.

## Operation
- States: IDLE(0), FETCH(1), DECODE(2), EXEC(3), WB(4).
- IDLE → FETCH when run=1.
- FETCH: write_ir=write_pc=1 for exactly one cycle → DECODE.
- DECODE: stall while ir_valid=0. Otherwise evaluate the condition via cond_check(ir[31:28], nzcv).
  - Fail → FETCH (or IDLE if run=0).
  - ir[27:26]≠00 → set illegal, → FETCH.
  - Else → EXEC.
- EXEC: decode fields are held stable for the ALU/shifter → WB.
- WB:
  - write_reg=1 unless opcode ∈ {1000,1001,1010,1011} (TST/TEQ/CMP/CMN).
  - Compares force write_nzcv=1; other ops set write_nzcv=S (ir[20]).
  - Rd=15 with a write → write_reg suppressed, illegal set.
  - Exit → FETCH if run=1, else IDLE.
- Decode (combinational from ir, valid DECODE through WB):
  - r_addr_a=ir[19:16], r_addr_b=ir[3:0], r_addr_c=ir[11:8], w_addr=ir[15:12], alu_op=ir[24:21].
- Immediate operand (I=ir[25]=1): b_imm=1, imm=ir[7:0], shift_op=ROR, shift_num={3'b0,ir[11:8],1'b0}, shift_num_sel=0.
- Register operand (I=0): b_imm=0, shift_op mapped from ir[6:5] (LSL/LSR/ASR/ROR).
  - ir[4]=1: shift_num_sel=1.
  - ir[4]=0: shift_num={3'b0,ir[11:7]}.
  - ir[6:5]=11 with shift amount 0 and ir[4]=0: shift_op=RRX.
- Outside DECODE..WB, all decode outputs are 0.

## Timing
- Reset (rst=0 at edge): state=IDLE. All strobes, decode outputs and illegal are 0. Reset takes priority in every state, including mid-instruction.
- Executed instruction: 4 cycles (FETCH, DECODE, EXEC, WB), plus one cycle per stall cycle in DECODE.
- Condition-failed or illegal instruction: 2 cycles.
- Strobes are single-cycle and registered; they assert in the cycle the state is entered.
- run falling mid-instruction: the instruction completes, then → IDLE.
- illegal clears only on reset.

## Configuration
- CTRL_SINGLE_STEP_EN defined: run is rising-edge detected with one internal register. Each rising edge executes exactly one instruction, IDLE→…→WB→IDLE; run held high does not repeat.
- Undefined: run is level-sensitive; instructions execute back-to-back while high.

## Structure
- Package cpu_pkg holds:
  - State enum.
  - Condition codes (EQ..AL).
  - DP opcode constants.
  - Shifter encodings: LSL=000, LSR=010, ASR=100, ROR=110, RRX=111.
- Sub-module cond_check: combinational; inputs cond[3:0] and nzcv[3:0]; output pass, with full ARM condition table; cond 1111 → fail.

## Test plan
- rst=0 for 2 cycles → state=0, all outputs 0, illegal=0.
- run=1, ir=0xE0812003 (ADD R2,R1,R3), ir_valid=1 → FETCH strobes in cycle 1; r_addr_a=1, r_addr_b=3, alu_op=0100, shift_op=LSL, shift_num=0; WB: write_reg=1, w_addr=2, write_nzcv=0.
- ir=0x03A00005 (MOVEQ R0,#5), nzcv=0000 → DECODE→FETCH, no write_reg. Same ir with nzcv=0100 → WB write_reg=1, w_addr=0, imm=5.
- ir=0xE3510010 (CMP R1,#0x10) → b_imm=1, imm=0x10, shift_op=ROR, shift_num=0; WB: write_reg=0, write_nzcv=1.
- ir=0xE5912000 (LDR) → illegal=1 after DECODE, no write_reg, next state FETCH; illegal persists until rst.
- rst=0 while in EXEC → IDLE next edge, all outputs 0; ir_valid=0 held in DECODE for 3 cycles → state stays 2, then proceeds.
